hazard_unit: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined core; successor to the two-source forwarding mux. Selects EX-stage operands from EX/MEM, MEM/WB or the ID/EX register for `NREAD` read ports. Detects load-use hazards, stalls for multi-cycle EX operations, and applies branch/exception flushes. Holds each port's resolved operand in a register for the whole of a multi-cycle stall, so results that retire during the stall are not lost.

---
 rtl/core_pkg.sv | 20 ++
 rtl/fwd_sel.sv | 45 ++++
 rtl/hazard_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-control types: hazard FSM encoding, forwarding select codes and
// default datapath widths.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT   = 5;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMcWait = 2'd1,
    StFlush  = 2'd2
  } hu_state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_src_e;

endpackage

// File: rtl/fwd_sel.sv
// One read port's forwarding comparators and 3:1 operand mux; the younger EX/MEM
// producer wins over MEM/WB, and x0 is never forwarded.
module fwd_sel
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned AW   = AW_DEFAULT
) (
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] rdata,
  input  logic [AW-1:0]   ex_mem_rd,
  input  logic            ex_mem_rw,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [AW-1:0]   mem_wb_rd,
  input  logic            mem_wb_rw,
  input  logic [XLEN-1:0] mem_wb_value,
  output logic [XLEN-1:0] data,
  output fwd_src_e        sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_rw && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign mem_wb_hit = mem_wb_rw && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    sel = FWD_REG;
    if (ex_mem_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    data = rdata;
    unique case (sel)
      FWD_EXMEM: data = ex_mem_result;
      FWD_MEMWB: data = mem_wb_value;
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding and hazard controller: per-port operand forwarding, load-use stalls,
// multi-cycle EX stalls with operand hold registers, and branch/exception flushes.
module hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned NREAD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   id_rs,
  input  logic [NREAD-1:0]      id_rs_used,
  input  logic [NREAD*AW-1:0]   ex_rs,
  input  logic [NREAD*XLEN-1:0] ex_rdata,
  input  logic [AW-1:0]         id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic [AW-1:0]         ex_mem_rd,
  input  logic                  ex_mem_rw,
  input  logic [XLEN-1:0]       ex_mem_result,
  input  logic [AW-1:0]         mem_wb_rd,
  input  logic                  mem_wb_rw,
  input  logic                  mem_wb_toreg,
  input  logic [XLEN-1:0]       mem_wb_readdata,
  input  logic [XLEN-1:0]       mem_wb_result,
  input  logic                  mc_start,
  input  logic                  mc_done,
  input  logic                  flush_req,
  output logic [NREAD*XLEN-1:0] fwd_data,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic [1:0]            state
);

  hu_state_e             state_q, state_d;
  logic [NREAD*XLEN-1:0] hold_q, hold_d;
  logic [NREAD*XLEN-1:0] live_data;
  logic [XLEN-1:0]       mem_wb_value;
  fwd_src_e              fwd_src [NREAD];
  logic                  load_use;

  assign mem_wb_value = mem_wb_toreg ? mem_wb_readdata : mem_wb_result;

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    fwd_sel #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_fwd_sel (
      .rs            (ex_rs[k*AW +: AW]),
      .rdata         (ex_rdata[k*XLEN +: XLEN]),
      .ex_mem_rd     (ex_mem_rd),
      .ex_mem_rw     (ex_mem_rw),
      .ex_mem_result (ex_mem_result),
      .mem_wb_rd     (mem_wb_rd),
      .mem_wb_rw     (mem_wb_rw),
      .mem_wb_value  (mem_wb_value),
      .data          (live_data[k*XLEN +: XLEN]),
      .sel           (fwd_src[k])
    );

    // Select is exported for coverage; the unused code 2'b11 must never appear.
    sel_legal_a : assert property (@(posedge clk) fwd_src[k] != 2'b11);
  end

  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      if (id_rs_used[k] && (id_rs[k*AW +: AW] == id_ex_rd)) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use && id_ex_memread && (id_ex_rd != '0);
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fwd_data  = live_data;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush_req) begin
          state_d   = StFlush;
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (mc_start) begin
          // The first EX cycle of a long op already stalls; operands are captured
          // now so later retirements cannot change what the unit consumes.
          if (!mc_done) begin
            state_d  = StMcWait;
            hold_d   = live_data;
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
          end
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      StMcWait: begin
        fwd_data = hold_q;
        if (mc_done) begin
          state_d = StRun;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end
      end
      StFlush: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = flush_req ? StFlush : StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: forwarding vector table, hand-built stall/flush/reset
// sequences, then random traffic against a behavioural model (plus a 3-port 64-bit build).
module tb_hazard_unit;

  localparam int RUN = 0;
  localparam int MCW = 1;
  localparam int FLS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  id_rs, ex_rs;
  logic [1:0]  id_rs_used;
  logic [63:0] ex_rdata;
  logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_memread, ex_mem_rw, mem_wb_rw, mem_wb_toreg;
  logic [31:0] ex_mem_result, mem_wb_readdata, mem_wb_result;
  logic        mc_start, mc_done, flush_req;
  logic [63:0] fwd_data;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id;
  logic [1:0]  state;

  hazard_unit #(.XLEN(32), .AW(5), .NREAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rdata(ex_rdata), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .ex_mem_rd(ex_mem_rd), .ex_mem_rw(ex_mem_rw), .ex_mem_result(ex_mem_result),
    .mem_wb_rd(mem_wb_rd), .mem_wb_rw(mem_wb_rw), .mem_wb_toreg(mem_wb_toreg),
    .mem_wb_readdata(mem_wb_readdata), .mem_wb_result(mem_wb_result),
    .mc_start(mc_start), .mc_done(mc_done), .flush_req(flush_req), .fwd_data(fwd_data),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .state(state)
  );

  // Wide build: forwarding only, control inputs idle.
  logic [14:0]  w_ex_rs;
  logic [191:0] w_ex_rdata, w_fwd_data;
  logic [4:0]   w_ex_mem_rd, w_mem_wb_rd;
  logic         w_ex_mem_rw, w_mem_wb_rw, w_mem_wb_toreg;
  logic [63:0]  w_ex_mem_result, w_mem_wb_readdata, w_mem_wb_result;
  logic         w_stall_if, w_stall_id, w_stall_ex, w_bubble_ex, w_flush_id;
  logic [1:0]   w_state;

  hazard_unit #(.XLEN(64), .AW(5), .NREAD(3)) dut_wide (
    .clk(clk), .rst_n(rst_n), .id_rs(15'h0), .id_rs_used(3'b000), .ex_rs(w_ex_rs),
    .ex_rdata(w_ex_rdata), .id_ex_rd(5'd0), .id_ex_memread(1'b0),
    .ex_mem_rd(w_ex_mem_rd), .ex_mem_rw(w_ex_mem_rw), .ex_mem_result(w_ex_mem_result),
    .mem_wb_rd(w_mem_wb_rd), .mem_wb_rw(w_mem_wb_rw), .mem_wb_toreg(w_mem_wb_toreg),
    .mem_wb_readdata(w_mem_wb_readdata), .mem_wb_result(w_mem_wb_result),
    .mc_start(1'b0), .mc_done(1'b0), .flush_req(1'b0), .fwd_data(w_fwd_data),
    .stall_if(w_stall_if), .stall_id(w_stall_id), .stall_ex(w_stall_ex),
    .bubble_ex(w_bubble_ex), .flush_id(w_flush_id), .state(w_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference operand: walk the in-flight producers youngest first; the first one
  // writing the requested register supplies it. x0 always reads the register file.
  function automatic logic [63:0] ref_operand(
      input logic [4:0] rs, input logic [63:0] regval,
      input logic [4:0] em_rd, input logic em_wr, input logic [63:0] em_val,
      input logic [4:0] wb_rd, input logic wb_wr, input logic [63:0] wb_val);
    logic [4:0]  pd [2];
    logic        pw [2];
    logic [63:0] pv [2];
    pd = '{em_rd, wb_rd};
    pw = '{em_wr, wb_wr};
    pv = '{em_val, wb_val};
    if (rs == 5'd0) return regval;
    for (int i = 0; i < 2; i++) begin
      if (pw[i] && pd[i] == rs) return pv[i];
    end
    return regval;
  endfunction

  int          m_state;
  int          m_next;
  bit          m_latch;
  logic [63:0] m_hold [2];
  logic [63:0] m_live [2];

  task automatic model_check();
    bit hz, s_all, s_fe, bub, fl;
    logic [63:0] wbv, wwbv, exp_f;
    wbv = {32'h0, mem_wb_toreg ? mem_wb_readdata : mem_wb_result};
    for (int k = 0; k < 2; k++) begin
      m_live[k] = ref_operand(ex_rs[k*5 +: 5], {32'h0, ex_rdata[k*32 +: 32]}, ex_mem_rd,
                              ex_mem_rw, {32'h0, ex_mem_result}, mem_wb_rd, mem_wb_rw, wbv);
    end
    hz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (id_ex_memread && id_ex_rd != 5'd0 && id_rs_used[k] && id_rs[k*5 +: 5] == id_ex_rd)
        hz = 1'b1;
    end
    s_all = 1'b0; s_fe = 1'b0; bub = 1'b0; fl = 1'b0;
    m_next = m_state; m_latch = 1'b0;
    case (m_state)
      RUN: begin
        if (flush_req) begin
          fl = 1'b1; bub = 1'b1; m_next = FLS;
        end else if (mc_start && !mc_done) begin
          s_all = 1'b1; m_next = MCW; m_latch = 1'b1;
        end else if (!mc_start && hz) begin
          s_fe = 1'b1; bub = 1'b1;
        end
      end
      MCW: begin
        s_all = !mc_done;
        if (mc_done) m_next = RUN;
      end
      default: begin
        fl = 1'b1; bub = 1'b1; m_next = flush_req ? FLS : RUN;
      end
    endcase
    chk("state", {62'h0, state}, m_state);
    chk("stall_if", stall_if, s_all | s_fe);
    chk("stall_id", stall_id, s_all | s_fe);
    chk("stall_ex", stall_ex, s_all);
    chk("bubble_ex", bubble_ex, bub);
    chk("flush_id", flush_id, fl);
    for (int k = 0; k < 2; k++) begin
      exp_f = (m_state == MCW) ? m_hold[k] : m_live[k];
      chk($sformatf("fwd%0d", k), {32'h0, fwd_data[k*32 +: 32]}, exp_f);
    end
    wwbv = w_mem_wb_toreg ? w_mem_wb_readdata : w_mem_wb_result;
    for (int k = 0; k < 3; k++) begin
      exp_f = ref_operand(w_ex_rs[k*5 +: 5], w_ex_rdata[k*64 +: 64], w_ex_mem_rd, w_ex_mem_rw,
                          w_ex_mem_result, w_mem_wb_rd, w_mem_wb_rw, wwbv);
      chk($sformatf("wide_fwd%0d", k), w_fwd_data[k*64 +: 64], exp_f);
    end
    chk("wide_ctrl", {57'h0, w_stall_if, w_stall_id, w_stall_ex, w_bubble_ex, w_flush_id,
                      w_state}, 64'h0);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_state = RUN;
      m_hold  = '{64'h0, 64'h0};
    end else begin
      if (m_latch) m_hold = m_live;
      m_state = m_next;
    end
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rdata = 64'h0000_0022_0000_0011;
    id_ex_rd = '0; id_ex_memread = 1'b0; ex_mem_rd = '0; ex_mem_rw = 1'b0;
    ex_mem_result = '0; mem_wb_rd = '0; mem_wb_rw = 1'b0; mem_wb_toreg = 1'b0;
    mem_wb_readdata = '0; mem_wb_result = '0; mc_start = 1'b0; mc_done = 1'b0;
    flush_req = 1'b0;
    w_ex_rs = '0; w_ex_rdata = '0; w_ex_mem_rd = '0; w_ex_mem_rw = 1'b0;
    w_ex_mem_result = '0; w_mem_wb_rd = '0; w_mem_wb_rw = 1'b0; w_mem_wb_toreg = 1'b0;
    w_mem_wb_readdata = '0; w_mem_wb_result = '0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  rs0, rs1;
    logic [4:0]  em_rd;
    logic        em_rw;
    logic [31:0] em_res;
    logic [4:0]  wb_rd;
    logic        wb_rw, wb_toreg;
    logic [31:0] wb_mem, wb_res;
    logic [31:0] exp0, exp1;
  } fvec_t;

  fvec_t vecs [6];
  int    stall_cycles;

  initial begin
    vecs[0] = '{"exmem_wins", 5'd5, 5'd0, 5'd5, 1'b1, 32'hAAAA, 5'd5, 1'b1, 1'b0, 32'h0,
                32'h5555, 32'hAAAA, 32'h22};
    vecs[1] = '{"x0_pending", 5'd0, 5'd0, 5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 1'b0, 32'h0,
                32'hBEEF, 32'h11, 32'h22};
    vecs[2] = '{"memwb_load", 5'd3, 5'd3, 5'd4, 1'b1, 32'h1, 5'd3, 1'b1, 1'b1, 32'hBEEF,
                32'h0F0F, 32'hBEEF, 32'hBEEF};
    vecs[3] = '{"memwb_alu", 5'd8, 5'd9, 5'd4, 1'b0, 32'h1, 5'd9, 1'b1, 1'b0, 32'h1,
                32'h9999, 32'h11, 32'h9999};
    vecs[4] = '{"rw_low", 5'd6, 5'd6, 5'd6, 1'b0, 32'hAAAA, 5'd6, 1'b0, 1'b0, 32'h1,
                32'h5555, 32'h11, 32'h22};
    vecs[5] = '{"split_ports", 5'd2, 5'd4, 5'd2, 1'b1, 32'h2222, 5'd4, 1'b1, 1'b0, 32'h1,
                32'h4444, 32'h2222, 32'h4444};

    idle();
    rst_n = 1'b0;
    m_state = RUN;
    m_hold = '{64'h0, 64'h0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state with idle inputs
    @(negedge clk);
    chk("rst_state", {62'h0, state}, 64'h0);
    chk("rst_ctrl", {59'h0, stall_if, stall_id, stall_ex, bubble_ex, flush_id}, 64'h0);
    chk("rst_fwd", fwd_data, 64'h0000_0022_0000_0011);
    model_check();
    advance();

    // Forwarding vector table
    foreach (vecs[i]) begin
      idle();
      ex_rs = {vecs[i].rs1, vecs[i].rs0};
      ex_mem_rd = vecs[i].em_rd; ex_mem_rw = vecs[i].em_rw; ex_mem_result = vecs[i].em_res;
      mem_wb_rd = vecs[i].wb_rd; mem_wb_rw = vecs[i].wb_rw; mem_wb_toreg = vecs[i].wb_toreg;
      mem_wb_readdata = vecs[i].wb_mem; mem_wb_result = vecs[i].wb_res;
      @(negedge clk);
      chk({vecs[i].name, "_p0"}, {32'h0, fwd_data[31:0]}, {32'h0, vecs[i].exp0});
      chk({vecs[i].name, "_p1"}, {32'h0, fwd_data[63:32]}, {32'h0, vecs[i].exp1});
      model_check();
      advance();
    end

    // Load-use on port 1: one stall cycle, then gone once the load moves on
    idle();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    @(negedge clk);
    chk("lu_stall", {61'h0, stall_if, stall_id, bubble_ex}, 64'h7);
    chk("lu_state", {62'h0, state}, 64'h0);
    model_check();
    advance();
    idle();
    @(negedge clk);
    chk("lu_after", {61'h0, stall_if, stall_id, bubble_ex}, 64'h0);
    model_check();
    advance();
    idle();
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b01;
    @(negedge clk);
    chk("lu_unused", {61'h0, stall_if, stall_id, bubble_ex}, 64'h0);
    model_check();
    advance();

    // Multi-cycle op: mc_done four cycles after mc_start, EX/MEM changes meanwhile
    idle();
    ex_rs = {5'd0, 5'd5}; ex_mem_rd = 5'd5; ex_mem_rw = 1'b1; ex_mem_result = 32'h1234;
    mc_start = 1'b1;
    stall_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        mc_start = 1'b0;
        ex_mem_result = 32'hFFFF;
      end
      mc_done = (c == 4);
      @(negedge clk);
      if (stall_if && stall_id && stall_ex) stall_cycles++;
      if (c <= 4) chk($sformatf("mc_hold_c%0d", c), {32'h0, fwd_data[31:0]}, 64'h1234);
      if (c >= 1 && c <= 4) chk($sformatf("mc_state_c%0d", c), {62'h0, state}, 64'h1);
      if (c == 5) begin
        chk("mc_back_run", {62'h0, state}, 64'h0);
        chk("mc_live_again", {32'h0, fwd_data[31:0]}, 64'hFFFF);
      end
      model_check();
      advance();
    end
    chk("mc_stall_len", stall_cycles, 64'd4);

    // Flush beats a simultaneous load-use hazard
    idle();
    flush_req = 1'b1;
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    @(negedge clk);
    chk("fl_ctrl", {59'h0, stall_if, stall_id, stall_ex, bubble_ex, flush_id}, 64'h3);
    model_check();
    advance();
    flush_req = 1'b0;
    @(negedge clk);
    chk("fl_state", {62'h0, state}, 64'h2);
    chk("fl_ctrl2", {59'h0, stall_if, stall_id, stall_ex, bubble_ex, flush_id}, 64'h3);
    model_check();
    advance();
    idle();
    @(negedge clk);
    chk("fl_done", {62'h0, state}, 64'h0);
    model_check();
    advance();

    // Reset during MC_WAIT aborts the wait
    idle();
    mc_start = 1'b1;
    @(negedge clk);
    model_check();
    advance();
    mc_start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmc_pre", {62'h0, state}, 64'h1);
    model_check();
    advance();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmc_state", {62'h0, state}, 64'h0);
    chk("rstmc_ctrl", {59'h0, stall_if, stall_id, stall_ex, bubble_ex, flush_id}, 64'h0);
    chk("rstmc_fwd", fwd_data, 64'h0000_0022_0000_0011);
    model_check();
    advance();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      id_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used = 2'($urandom);
      ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_rdata = {$urandom, $urandom};
      id_ex_rd = 5'($urandom_range(0, 3)); id_ex_memread = 1'($urandom);
      ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_rw = 1'($urandom);
      ex_mem_result = $urandom;
      mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_rw = 1'($urandom);
      mem_wb_toreg = 1'($urandom); mem_wb_readdata = $urandom; mem_wb_result = $urandom;
      mc_start = ($urandom_range(0, 3) == 0);
      mc_done = ($urandom_range(0, 2) == 0);
      flush_req = ($urandom_range(0, 7) == 0);
      w_ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      w_ex_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      w_ex_mem_rd = 5'($urandom_range(0, 3)); w_ex_mem_rw = 1'($urandom);
      w_ex_mem_result = {$urandom, $urandom};
      w_mem_wb_rd = 5'($urandom_range(0, 3)); w_mem_wb_rw = 1'($urandom);
      w_mem_wb_toreg = 1'($urandom);
      w_mem_wb_readdata = {$urandom, $urandom}; w_mem_wb_result = {$urandom, $urandom};
      @(negedge clk);
      model_check();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
